// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared PE types: FSM state encodings and default widths
package pe_pkg;

    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_CONFIG_BIT = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_STREAM = 2'b01,
        S_DONE   = 2'b10
    } psum_state_t;

endpackage

// File: rtl/psum_skid_buf.sv
// rtl/psum_skid_buf.sv - 2-entry FIFO decoupling psum acceptance from output FIFO pushes
module psum_skid_buf #(
    parameter int DATA_WIDTH = pe_pkg::PE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    // Storage and pointers; a simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Head word is presented as zero while the buffer is empty
    always_comb begin
        head_data = (occ != 2'd0) ? mem[rd_ptr] : '0;
    end

endmodule

// File: rtl/psum_write_controller.sv
// rtl/psum_write_controller.sv - moves a counted job of psum words from the PE into the output FIFO
module psum_write_controller
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int CONFIG_BIT = PE_CONFIG_BIT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  start,
    input  logic [CONFIG_BIT-1:0] cfg_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  full,
    output logic                  wen,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  first_write,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CONFIG_BIT-1:0] CNT_ONE = CONFIG_BIT'(1);

    psum_state_t           state_q;
    psum_state_t           state_d;
    logic [CONFIG_BIT-1:0] cfg_q;
    logic [CONFIG_BIT-1:0] acc_cnt;
    logic [CONFIG_BIT-1:0] wr_cnt;
    logic [1:0]            occ;
    logic                  accept;
    logic                  start_ok;
    logic                  last_push;

    assign accept    = in_valid & in_ready;
    assign start_ok  = en & start & (state_q == S_IDLE);
    assign last_push = wen & (wr_cnt == cfg_q - CNT_ONE);

    psum_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept),
        .push_data (in_data),
        .pop       (wen),
        .head_data (wdata),
        .occ       (occ)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; S_DONE always returns to idle so done can never stretch
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (cfg_count != '0) ? S_STREAM : S_DONE;
                end
            end
            S_STREAM: begin
                if (last_push) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; in_ready depends only on registered state and en, never on full or in_valid
    always_comb begin
        in_ready = en & (state_q == S_STREAM) & (occ < 2'd2) & (acc_cnt < cfg_q);
        wen      = en & ~full & (occ != 2'd0);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    // Job bookkeeping: word limit, accept/push counters and the sticky first_write flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_q       <= '0;
            acc_cnt     <= '0;
            wr_cnt      <= '0;
            first_write <= 1'b0;
        end else if (start_ok) begin
            cfg_q       <= cfg_count;
            acc_cnt     <= '0;
            wr_cnt      <= '0;
            first_write <= 1'b0;
        end else begin
            if (accept) begin
                acc_cnt <= acc_cnt + CNT_ONE;
            end
            if (wen) begin
                wr_cnt      <= wr_cnt + CNT_ONE;
                first_write <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_write_controller.sv
// tb/tb_psum_write_controller.sv - directed self-checking bench for psum_write_controller
module tb_psum_write_controller;

    localparam int DW = 16;
    localparam int CB = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          start;
    logic [CB-1:0] cfg_count;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          full;
    logic          wen;
    logic [DW-1:0] wdata;
    logic          first_write;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            src_idx = 0;
    logic [DW-1:0] base = '0;
    logic [DW-1:0] pushes [$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_wen_cyc = 0;
    int            wen_no_en = 0;

    assign in_data = base + DW'(src_idx);

    psum_write_controller #(
        .DATA_WIDTH (DW),
        .CONFIG_BIT (CB)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .start       (start),
        .cfg_count   (cfg_count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .full        (full),
        .wen         (wen),
        .wdata       (wdata),
        .first_write (first_write),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic acc;
        #1;
        acc = in_valid && in_ready;
        if (wen) begin
            pushes.push_back(wdata);
            last_wen_cyc = cyc;
            if (!en) wen_no_en++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) src_idx++;
    endtask

    task automatic new_job(input logic [DW-1:0] b);
        pushes.delete();
        src_idx   = 0;
        base      = b;
        done_cnt  = 0;
        wen_no_en = 0;
    endtask

    task automatic start_job(input logic [CB-1:0] n);
        cfg_count = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_until_done(input int maxc);
        for (int i = 0; i < maxc && done_cnt == 0; i++) tick();
    endtask

    task automatic check_seq(input string tag, input int n);
        chk({tag, "_count"}, pushes.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < pushes.size()) chk({tag, "_word"}, {16'h0, pushes[i]}, {16'h0, base + DW'(i)});
        end
    endtask

    initial begin
        rstn      = 1'b0;
        en        = 1'b0;
        start     = 1'b0;
        cfg_count = '0;
        in_valid  = 1'b0;
        full      = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wen", wen, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_first_write", first_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        en = 1'b1;
        tick();

        // Reset in the middle of a job
        new_job(16'h1000);
        in_valid = 1'b1;
        start_job(5'd8);
        for (int i = 0; i < 20 && pushes.size() < 3; i++) tick();
        chk("t1_pushed", pushes.size(), 3);
        chk("t1_busy_before", busy, 1);
        #1 rstn = 1'b0;
        #1;
        chk("t1_in_ready", in_ready, 0);
        chk("t1_wen", wen, 0);
        chk("t1_wdata", wdata, 0);
        chk("t1_first_write", first_write, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        #1 rstn = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("t1_idle_after", busy, 0);
        chk("t1_wen_after", wen, 0);

        // Streaming, no backpressure
        new_job(16'h2000);
        in_valid = 1'b1;
        start_job(5'd4);
        run_until_done(20);
        chk("t2_done_seen", done_cnt, 1);
        check_seq("t2", 4);
        chk("t2_done_latency", done_cyc - last_wen_cyc, 1);
        chk("t2_first_write", first_write, 1);
        tick();
        chk("t2_done_one_cycle", done, 0);

        // Backpressure: full held for 10 cycles after the first push
        new_job(16'h3000);
        in_valid = 1'b1;
        start_job(5'd6);
        for (int i = 0; i < 20 && pushes.size() < 1; i++) tick();
        full = 1'b1;
        repeat (10) tick();
        chk("t3_held_pushes", pushes.size(), 1);
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_accepted", src_idx, 3);
        chk("t3_wen_full", wen, 0);
        full = 1'b0;
        run_until_done(30);
        chk("t3_done_seen", done_cnt, 1);
        check_seq("t3", 6);

        // Zero-length job
        new_job(16'h4000);
        in_valid = 1'b1;
        start_job(5'd0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_wen", wen, 0);
        tick();
        chk("t4_done_clear", done, 0);
        chk("t4_busy_clear", busy, 0);
        chk("t4_first_write", first_write, 0);
        chk("t4_pushes", pushes.size(), 0);
        chk("t4_accepts", src_idx, 0);

        // en toggling every other cycle
        new_job(16'h5000);
        in_valid = 1'b1;
        start_job(5'd5);
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            en = (i % 2 == 0);
            tick();
        end
        en = 1'b1;
        chk("t5_done_seen", done_cnt, 1);
        check_seq("t5", 5);
        chk("t5_wen_without_en", wen_no_en, 0);

        // start during streaming and surplus in_valid are ignored
        new_job(16'h6000);
        in_valid = 1'b1;
        start_job(5'd3);
        tick();
        tick();
        start_job(5'd7);
        run_until_done(20);
        repeat (4) tick();
        check_seq("t6", 3);
        chk("t6_accepts", src_idx, 3);
        chk("t6_done_count", done_cnt, 1);
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
